// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write side: register count,
// address width, the hardwired-zero register index and a one-hot helper.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd31;

    // One-hot image of a register address (bit k set for address k).
    function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t addr);
        logic [NUM_REGS-1:0] one_s;
        one_s = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one_s << addr;
    endfunction

endpackage

// File: rtl/regfile_write_decoder.sv
// 5-to-32 one-hot load-enable decoder for the register array.
// Purely combinational; all outputs low when en is low.
module write_decoder
    import regfile_pkg::*;
(
    input  reg_addr_t             addr,
    input  logic                  en,
    output logic [NUM_REGS-1:0]   load_en
);

    // Decode the drained address into a single load enable.
    always_comb begin
        load_en = {NUM_REGS{1'b0}};
        if (en) begin
            load_en = addr_onehot(addr);
        end else begin
            load_en = {NUM_REGS{1'b0}};
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32-entry register file. Write-back requests are taken
// over a valid/ready handshake into a small FIFO and drained one per cycle
// (unless hold is asserted) through the one-hot decoder into the array.
// The pending mask flags registers targeted by any still-buffered entry.
//
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire register 31 to
// zero. Writes to it are still buffered and drained in order, but never load.
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int n     = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [n-1:0]                wr_data,
    input  logic                        hold,
    output logic [NUM_REGS*n-1:0]       regs,
    output logic [NUM_REGS-1:0]         pending,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        reg_addr_t      addr;
        logic [n-1:0]   data;
    } wr_req_t;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(1'b0);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [NUM_REGS-1:0] WRITABLE_MASK = ~addr_onehot(ZERO_REG);
`else
    localparam logic [NUM_REGS-1:0] WRITABLE_MASK = {NUM_REGS{1'b1}};
`endif

    wr_req_t                fifo_r [DEPTH];
    logic [PTR_W-1:0]       head_r;
    logic [PTR_W-1:0]       tail_r;
    logic [PTR_W:0]         count_r;
    logic                   ready_r;
    logic [n-1:0]           regs_r [NUM_REGS];

    logic                   push_s;
    logic                   pop_s;
    logic [PTR_W:0]         count_next_s;
    wr_req_t                head_req_s;
    logic [NUM_REGS-1:0]    load_en_s;
    logic [NUM_REGS-1:0]    load_mask_s;
    logic [NUM_REGS-1:0]    pending_s;

    assign head_req_s  = fifo_r[head_r];
    assign load_mask_s = load_en_s & WRITABLE_MASK;

    // Handshake qualification and next occupancy; push and pop together keep count.
    always_comb begin
        push_s       = 1'b0;
        pop_s        = 1'b0;
        count_next_s = count_r;
        push_s = wr_valid && ready_r;
        if (count_r != CNT_ZERO) begin
            pop_s = !hold;
        end else begin
            pop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, wrapping pointers, occupancy and registered ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= '{addr: 5'd0, data: {n{1'b0}}};
            end
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= CNT_ZERO;
            ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_r[tail_r].addr <= wr_addr;
                fifo_r[tail_r].data <= wr_data;
                tail_r              <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != FULL_CNT);
        end
    end

    write_decoder u_write_decoder (
        .addr    (head_req_s.addr),
        .en      (pop_s),
        .load_en (load_en_s)
    );

    // Register array: load the head data into the decoded register on drain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_r[k] <= {n{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (load_mask_s[k]) begin
                    regs_r[k] <= head_req_s.data;
                end
            end
        end
    end

    // Pending mask rebuilt from every occupied FIFO slot (offset from head < count).
    always_comb begin
        logic [PTR_W-1:0] offset_v;
        pending_s = {NUM_REGS{1'b0}};
        offset_v  = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offset_v = i[PTR_W-1:0] - head_r;
            if ({1'b0, offset_v} < count_r) begin
                pending_s = pending_s | addr_onehot(fifo_r[i].addr);
            end else begin
                pending_s = pending_s;
            end
        end
        pending_s = pending_s & WRITABLE_MASK;
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs[k*n +: n] = regs_r[k];
    end

    assign pending  = pending_s;
    assign count    = count_r;
    assign wr_ready = ready_r;

endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port. A queue scoreboard holds every
// accepted request; each clock step pops the head when a drain is due and
// compares the full register image, count, pending mask and ready.
module tb_regfile_write_port;

    localparam int N     = 8;
    localparam int DEPTH = 4;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]   addr;
        logic [N-1:0] data;
    } req_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [4:0]        wr_addr;
    logic [N-1:0]      wr_data;
    logic              hold;
    logic [32*N-1:0]   regs;
    logic [31:0]       pending;
    logic [2:0]        count;

    req_t              sb_q [$];
    logic [N-1:0]      exp_regs [32];
    int                checks   = 0;
    int                failures = 0;

    regfile_write_port #(.n(N), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hold     (hold),
        .regs     (regs),
        .pending  (pending),
        .count    (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32*N-1:0] exp_flat();
        logic [32*N-1:0] f;
        f = {(32*N){1'b0}};
        for (int k = 0; k < 32; k++) f[k*N +: N] = exp_regs[k];
        return f;
    endfunction

    function automatic logic [31:0] exp_pending();
        logic [31:0] p;
        p = 32'd0;
        foreach (sb_q[i]) p[sb_q[i].addr] = 1'b1;
        if (ZERO_EN) p[31] = 1'b0;
        return p;
    endfunction

    // One clock: decide push/pop from the model, advance, compare everything.
    task automatic step(input string tag);
        bit   do_push;
        bit   do_pop;
        req_t e;
        chk({tag, "_ready"}, wr_ready, (sb_q.size() < DEPTH));
        do_push = wr_valid && (sb_q.size() < DEPTH);
        do_pop  = (sb_q.size() > 0) && !hold;
        @(posedge clock);
        #1;
        if (do_pop) begin
            e = sb_q.pop_front();
            if (!(ZERO_EN && e.addr == 5'd31)) exp_regs[e.addr] = e.data;
        end
        if (do_push) begin
            e.addr = wr_addr;
            e.data = wr_data;
            sb_q.push_back(e);
        end
        chk({tag, "_count"}, count, sb_q.size());
        chk({tag, "_regs"}, regs, exp_flat());
        chk({tag, "_pending"}, pending, exp_pending());
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_regs"}, regs, 256'd0);
        chk({tag, "_count"}, count, 3'd0);
        chk({tag, "_pending"}, pending, 32'd0);
        chk({tag, "_ready"}, wr_ready, 1'b1);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
    task automatic async_reset(input string tag);
        wr_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state(tag);
        sb_q.delete();
        for (int k = 0; k < 32; k++) exp_regs[k] = {N{1'b0}};
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = {N{1'b0}};
        hold     = 1'b0;
        for (int k = 0; k < 32; k++) exp_regs[k] = {N{1'b0}};
        #12;
        check_reset_state("por");
        reset_n = 1'b1;

        // Single write: addr 5, 0xA5.
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 8'hA5;
        step("single_acc");
        chk("single_pend5_high", pending[5], 1'b1);
        wr_valid = 1'b0;
        step("single_drain");
        chk("single_reg5", regs[5*N +: N], 8'hA5);
        chk("single_pend5_low", pending[5], 1'b0);

        // Back-to-back writes to 1,2,3.
        for (int i = 1; i <= 3; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 8'(8'h10 + i);
            step("b2b");
            chk("b2b_count_le1", (count <= 3'd1), 1'b1);
        end
        wr_valid = 1'b0;
        step("b2b_tail");
        chk("b2b_reg3", regs[3*N +: N], 8'h13);

        // Fill and stall: four writes to addr 7 under hold.
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 8'(i);
            step("fill");
        end
        chk("fill_count4", count, 3'd4);
        chk("fill_ready0", wr_ready, 1'b0);
        wr_addr = 5'd9; wr_data = 8'hEE;
        step("fill_reject");
        chk("fill_reg9_untouched", regs[9*N +: N], 8'h00);
        wr_valid = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("drain");
        end
        chk("drain_reg7", regs[7*N +: N], 8'h04);
        chk("drain_pend7", pending[7], 1'b0);
        chk("drain_reg9_untouched", regs[9*N +: N], 8'h00);

        // Push/pop with pointer wrap under toggling hold.
        for (int i = 0; i < 40; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = 8'($urandom_range(0, 255));
            hold     = ((i % 7) < 3);
            step("wrap");
        end
        wr_valid = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 5; i++) step("wrap_flush");
        chk("wrap_empty", count, 3'd0);

        // Register 31 behaviour.
        wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 8'hFF;
        step("zero_acc");
        chk("zero_pend31", pending[31], ZERO_EN ? 1'b0 : 1'b1);
        wr_valid = 1'b0;
        step("zero_drain");
        chk("zero_reg31", regs[31*N +: N], ZERO_EN ? 8'h00 : 8'hFF);

        // Reset in the middle of buffered traffic.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(20 + i); wr_data = 8'(8'h60 + i);
            step("mid_fill");
        end
        async_reset("mid_rst");
        hold = 1'b0;
        step("post_rst");
        chk("post_rst_reg20", regs[20*N +: N], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
